// File: rtl/cla_serial_adder.sv
// Multi-cycle WIDTH-bit adder: operands are streamed one nibble per cycle through a
// single 4-bit carry look-ahead slice, with the carry held in a register between nibbles.

module cla (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  // Carries are expanded from generate/propagate terms so no carry ripples inside the slice.
  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    sum  = p ^ c[3:0];
    cout = c[4];
  end

endmodule

module cla_serial_adder #(
  parameter int WIDTH   = 16,
  parameter int NIBBLES = WIDTH / 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout
);

  localparam int CNT_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q,     state_d;
  logic [WIDTH-1:0] a_q,         a_d;
  logic [WIDTH-1:0] b_q,         b_d;
  logic [WIDTH-1:0] result_q,    result_d;
  logic             carry_q,     carry_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic             in_ready_q,  in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_sum_q,   out_sum_d;
  logic             out_cout_q,  out_cout_d;

  logic [3:0] nib_sum;
  logic       nib_cout;

  cla u_cla (
    .a    (a_q[3:0]),
    .b    (b_q[3:0]),
    .cin  (carry_q),
    .sum  (nib_sum),
    .cout (nib_cout)
  );

  // Next-state logic; outputs are registered so in_ready/out_valid depend on state only.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    result_d    = result_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_cout_d  = out_cout_q;

    case (state_q)
      IDLE: begin
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        if (in_valid && in_ready_q) begin
          a_d        = in_a;
          b_d        = in_b;
          carry_d    = in_cin;
          cnt_d      = '0;
          state_d    = RUN;
          in_ready_d = 1'b0;
        end
      end

      RUN: begin
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        a_d         = a_q >> 4;
        b_d         = b_q >> 4;
        result_d    = result_q >> 4;
        result_d[WIDTH-1 -: 4] = nib_sum;
        carry_d     = nib_cout;
        cnt_d       = cnt_q + CNT_W'(1);
        // The final nibble goes straight into the output registers as well.
        if (cnt_q == LAST_NIB) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          out_sum_d   = result_d;
          out_cout_d  = nib_cout;
        end
      end

      DONE: begin
        in_ready_d = 1'b0;
        if (out_valid_q && out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end

      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_cout_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      result_q    <= result_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_cout_q  <= out_cout_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_cout  = out_cout_q;

endmodule

// File: tb/tb_cla_serial_adder.sv
// Directed and random checks of cla_serial_adder (WIDTH = 16) using immediate assertions.

module tb_cla_serial_adder;

  localparam int WIDTH   = 16;
  localparam int NIBBLES = WIDTH / 4;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;

  int compared   = 0;
  int mismatched = 0;

  cla_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offers one operand pair, checks latency and result, stalls, then releases the result.
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic cin, input logic [WIDTH-1:0] exp_sum,
                        input logic exp_cout, input int stall, input string tag);
    int cycles;
    cycles = 0;
    while (!in_ready && cycles < 20) begin
      step();
      cycles++;
    end
    check({tag, "_in_ready_before_accept"}, 32'(in_ready), 32'd1);
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    in_a     = WIDTH'($urandom);
    in_b     = WIDTH'($urandom);
    in_cin   = 1'($urandom);
    cycles   = 0;
    while (!out_valid && cycles < 20) begin
      check({tag, "_in_ready_low_in_run"}, 32'(in_ready), 32'd0);
      step();
      cycles++;
    end
    check({tag, "_latency"}, 32'(cycles), 32'(NIBBLES));
    check({tag, "_sum"}, 32'(out_sum), 32'(exp_sum));
    check({tag, "_cout"}, 32'(out_cout), 32'(exp_cout));
    for (int i = 0; i < stall; i++) begin
      step();
      check({tag, "_stall_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_stall_sum"}, 32'(out_sum), 32'(exp_sum));
      check({tag, "_stall_cout"}, 32'(out_cout), 32'(exp_cout));
      check({tag, "_ready_and_valid"}, 32'(in_ready & out_valid), 32'd0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "_released_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_released_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic             rc;
    logic [WIDTH:0]   ref_full;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_cin    = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_sum", 32'(out_sum), 32'h0000);
    check("reset_out_cout", 32'(out_cout), 32'd0);
    rst = 1'b0;
    step();

    run_op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 0, "basic");
    run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 0, "ripple1");
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 0, "ripple2");
    run_op(16'h00FF, 16'h0F0F, 1'b0, 16'h100E, 1'b0, 6, "backpressure");
    run_op(16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1, "cin_only");

    // Reset pulsed during the second RUN cycle discards the in-flight add.
    in_a     = 16'h1234;
    in_b     = 16'h1111;
    in_cin   = 1'b1;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    #2;
    check("midreset_in_ready", 32'(in_ready), 32'd1);
    check("midreset_out_valid", 32'(out_valid), 32'd0);
    check("midreset_out_sum", 32'(out_sum), 32'h0000);
    check("midreset_out_cout", 32'(out_cout), 32'd0);
    step();
    rst = 1'b0;
    step();
    check("post_reset_out_valid", 32'(out_valid), 32'd0);
    run_op(16'h0003, 16'h0005, 1'b0, 16'h0008, 1'b0, 0, "after_reset");

    for (int n = 0; n < 50; n++) begin
      ra       = WIDTH'($urandom);
      rb       = WIDTH'($urandom);
      rc       = 1'($urandom);
      ref_full = {1'b0, ra} + {1'b0, rb} + {{WIDTH{1'b0}}, rc};
      run_op(ra, rb, rc, ref_full[WIDTH-1:0], ref_full[WIDTH], $urandom_range(0, 3), "stream");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
